// File: rtl/wb_arb_pkg.sv
// Shared definitions for the Wishbone slave arbiter family.
//   arb_state_t      : transaction scheduler states
//   WB_DW / WB_AW    : Wishbone data and address widths
//   ERR_DATA_DEFAULT : read word returned when an access is terminated locally
//   sat_inc8         : 8-bit increment that sticks at 255
package wb_arb_pkg;

  localparam int WB_DW = 32;
  localparam int WB_AW = 32;

  localparam logic [WB_DW-1:0] ERR_DATA_DEFAULT = 32'hDEAD_BEEF;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_FWD  = 2'd1,
    ST_ERR  = 2'd2,
    ST_ACK  = 2'd3
  } arb_state_t;

  function automatic logic [7:0] sat_inc8(input logic [7:0] value);
    return (value == 8'hFF) ? value : value + 8'd1;
  endfunction

endpackage

// File: rtl/wb_arb_timeout.sv
// Wait-cycle counter used to bound how long a downstream slave may stall.
//   clk    : clock
//   rst_n  : asynchronous active-low reset
//   clr    : synchronous clear (wins over en)
//   en     : count one cycle
//   limit  : number of enabled cycles before expiry (1..255)
//   expire : high during the enabled cycle that brings the count to limit
module wb_arb_timeout
  import wb_arb_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic       clr,
  input  logic       en,
  input  logic [7:0] limit,
  output logic       expire
);

  logic [7:0] count_reg;
  logic [7:0] count_next;

  always_comb begin
    count_next = count_reg;
    if (clr) begin
      count_next = '0;
    end else if (en) begin
      count_next = sat_inc8(count_reg);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_reg <= '0;
    end else begin
      count_reg <= count_next;
    end
  end

  // 9-bit sum so a count of 255 cannot wrap into a false match.
  assign expire = en && !clr && (({1'b0, count_reg} + 9'd1) == {1'b0, limit});

endmodule

// File: rtl/wb_slave_arbiter.sv
// Wishbone transaction scheduler between the user-area slave port and up to
// four peripherals. Each access is decoded to one peripheral window and
// forwarded as a single registered transaction; misses and stalled slaves are
// terminated locally with an error word so the master can never hang.
//   wb_clk_i, wb_rst_n_i       : clock, asynchronous active-low reset
//   wbs_cyc/stb/we/sel/adr/dat : master request
//   wbs_ack_o, wbs_dat_o       : master acknowledge and read data
//   s_cyc_o, s_stb_o           : per-slave one-hot cycle/strobe
//   s_we/sel/adr/dat_o         : shared registered request
//   s_ack_i, s_dat_i           : slave acknowledges and read data (slave k at [32k+31:32k])
//   err_clr_i                  : clears the sticky error flag
//   err_irq_o, err_cnt_o       : sticky error flag, saturating error count
module wb_slave_arbiter
  import wb_arb_pkg::*;
#(
  parameter int               NSLV     = 4,
  parameter logic [7:0]       BASE_HI  = 8'h30,
  parameter int               WIN_BITS = 16,
  parameter int               TIMEOUT  = 255,
  parameter logic [WB_DW-1:0] ERR_DATA = ERR_DATA_DEFAULT
) (
  input  logic                  wb_clk_i,
  input  logic                  wb_rst_n_i,
  input  logic                  wbs_cyc_i,
  input  logic                  wbs_stb_i,
  input  logic                  wbs_we_i,
  input  logic [3:0]            wbs_sel_i,
  input  logic [WB_AW-1:0]      wbs_adr_i,
  input  logic [WB_DW-1:0]      wbs_dat_i,
  output logic                  wbs_ack_o,
  output logic [WB_DW-1:0]      wbs_dat_o,
  output logic [NSLV-1:0]       s_cyc_o,
  output logic [NSLV-1:0]       s_stb_o,
  output logic                  s_we_o,
  output logic [3:0]            s_sel_o,
  output logic [WB_AW-1:0]      s_adr_o,
  output logic [WB_DW-1:0]      s_dat_o,
  input  logic [NSLV-1:0]       s_ack_i,
  input  logic [WB_DW*NSLV-1:0] s_dat_i,
  input  logic                  err_clr_i,
  output logic                  err_irq_o,
  output logic [7:0]            err_cnt_o
);

  arb_state_t       state_reg, state_next;
  logic [1:0]       idx_reg, idx_next;
  logic [WB_AW-1:0] adr_reg, adr_next;
  logic [WB_DW-1:0] dat_reg, dat_next;
  logic [3:0]       sel_reg, sel_next;
  logic             we_reg, we_next;
  logic [NSLV-1:0]  stb_reg, stb_next;
  logic [WB_DW-1:0] rdata_reg, rdata_next;
  logic             ack_seen_reg, ack_seen_next;
  logic             err_irq_reg;
  logic [7:0]       err_cnt_reg;

  // Address decode of the live master request.
  logic       req;
  logic [1:0] dec_idx;
  logic       dec_hit;

  assign req     = wbs_cyc_i & wbs_stb_i;
  assign dec_idx = wbs_adr_i[WIN_BITS+1:WIN_BITS];
  assign dec_hit = (wbs_adr_i[31:24] == BASE_HI) && (32'(dec_idx) < 32'(NSLV));

  // Per-slave decode, ack qualification and read-data unpacking. An ack only
  // counts while that slave's strobe is being driven, so acks from other
  // slaves (or a late repeat after the strobe dropped) are ignored.
  logic [NSLV-1:0]  dec_onehot;
  logic [NSLV-1:0]  ack_match;
  logic [WB_DW-1:0] slv_dat [NSLV];

  genvar gi;
  generate
    for (gi = 0; gi < NSLV; gi++) begin : g_slv
      assign dec_onehot[gi] = (dec_idx == 2'(gi));
      assign ack_match[gi]  = s_ack_i[gi] & stb_reg[gi];
      assign slv_dat[gi]    = s_dat_i[WB_DW*gi +: WB_DW];
    end
  endgenerate

  logic             slv_ack;
  logic [WB_DW-1:0] sel_dat;

  assign slv_ack = |ack_match;

  always_comb begin
    sel_dat = '0;
    for (int k = 0; k < NSLV; k++) begin
      if (idx_reg == 2'(k)) begin
        sel_dat = slv_dat[k];
      end
    end
  end

  // Wait counter runs only while forwarding and is cleared in every other state.
  logic tmo_en;
  logic tmo_expire;

  assign tmo_en = (state_reg == ST_FWD);

  wb_arb_timeout u_timeout (
    .clk    (wb_clk_i),
    .rst_n  (wb_rst_n_i),
    .clr    (!tmo_en),
    .en     (tmo_en),
    .limit  (8'(TIMEOUT)),
    .expire (tmo_expire)
  );

  always_comb begin
    state_next    = state_reg;
    idx_next      = idx_reg;
    adr_next      = adr_reg;
    dat_next      = dat_reg;
    sel_next      = sel_reg;
    we_next       = we_reg;
    stb_next      = '0;
    rdata_next    = rdata_reg;
    ack_seen_next = 1'b0;

    case (state_reg)
      ST_IDLE: begin
        if (req) begin
          if (dec_hit) begin
            idx_next   = dec_idx;
            adr_next   = wbs_adr_i;
            dat_next   = wbs_dat_i;
            sel_next   = wbs_sel_i;
            we_next    = wbs_we_i;
            stb_next   = dec_onehot;
            state_next = ST_FWD;
          end else begin
            state_next = ST_ERR;
          end
        end
      end
      ST_FWD: begin
        // The slave ack is registered (ack_seen) before the master is
        // acknowledged, keeping s_ack_i off the wbs_ack_o path. An ack in the
        // same cycle the counter expires still completes the transfer.
        if (!wbs_cyc_i) begin
          state_next = ST_IDLE;
        end else if (ack_seen_reg) begin
          state_next = ST_ACK;
        end else if (slv_ack) begin
          rdata_next    = sel_dat;
          ack_seen_next = 1'b1;
        end else if (tmo_expire) begin
          state_next = ST_ERR;
        end else begin
          stb_next = stb_reg;
        end
      end
      ST_ERR: begin
        rdata_next = ERR_DATA;
        state_next = ST_ACK;
      end
      ST_ACK: begin
        state_next = ST_IDLE;
      end
      default: begin
        state_next = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge wb_clk_i or negedge wb_rst_n_i) begin
    if (!wb_rst_n_i) begin
      state_reg    <= ST_IDLE;
      idx_reg      <= '0;
      adr_reg      <= '0;
      dat_reg      <= '0;
      sel_reg      <= '0;
      we_reg       <= 1'b0;
      stb_reg      <= '0;
      rdata_reg    <= '0;
      ack_seen_reg <= 1'b0;
      err_irq_reg  <= 1'b0;
      err_cnt_reg  <= '0;
    end else begin
      state_reg    <= state_next;
      idx_reg      <= idx_next;
      adr_reg      <= adr_next;
      dat_reg      <= dat_next;
      sel_reg      <= sel_next;
      we_reg       <= we_next;
      stb_reg      <= stb_next;
      rdata_reg    <= rdata_next;
      ack_seen_reg <= ack_seen_next;
      // A new error outranks a simultaneous clear request.
      if (state_reg == ST_ERR) begin
        err_irq_reg <= 1'b1;
        err_cnt_reg <= sat_inc8(err_cnt_reg);
      end else if (err_clr_i) begin
        err_irq_reg <= 1'b0;
      end
    end
  end

  assign wbs_ack_o = (state_reg == ST_ACK);
  assign wbs_dat_o = rdata_reg;
  assign s_cyc_o   = stb_reg;
  assign s_stb_o   = stb_reg;
  assign s_we_o    = we_reg;
  assign s_sel_o   = sel_reg;
  assign s_adr_o   = adr_reg;
  assign s_dat_o   = dat_reg;
  assign err_irq_o = err_irq_reg;
  assign err_cnt_o = err_cnt_reg;

endmodule

// File: tb/tb_wb_slave_arbiter.sv
module tb_wb_slave_arbiter;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic         cyc = 1'b0, stb = 1'b0, we = 1'b0, use3 = 1'b0, err_clr = 1'b0;
  logic [3:0]   sel = 4'h0;
  logic [31:0]  adr = 32'h0, wdat = 32'h0;
  logic [3:0]   s_ack = 4'h0;
  logic [127:0] s_dat = 128'h0;
  logic         cyc_main, cyc3;

  assign cyc_main = cyc & ~use3;
  assign cyc3     = cyc & use3;

  logic         ack, s_we, irq;
  logic [31:0]  rdat, s_adr, s_wdat;
  logic [3:0]   s_cyc, s_stb, s_sel;
  logic [7:0]   cnt;

  logic         ack3, s_we3, irq3;
  logic [31:0]  rdat3, s_adr3, s_wdat3;
  logic [2:0]   s_cyc3, s_stb3;
  logic [3:0]   s_sel3;
  logic [7:0]   cnt3;

  int n_cmp = 0;
  int n_bad = 0;

  wb_slave_arbiter #(.NSLV(4), .TIMEOUT(4)) dut (
    .wb_clk_i(clk), .wb_rst_n_i(rst_n),
    .wbs_cyc_i(cyc_main), .wbs_stb_i(stb), .wbs_we_i(we),
    .wbs_sel_i(sel), .wbs_adr_i(adr), .wbs_dat_i(wdat),
    .wbs_ack_o(ack), .wbs_dat_o(rdat),
    .s_cyc_o(s_cyc), .s_stb_o(s_stb), .s_we_o(s_we), .s_sel_o(s_sel),
    .s_adr_o(s_adr), .s_dat_o(s_wdat),
    .s_ack_i(s_ack), .s_dat_i(s_dat),
    .err_clr_i(err_clr), .err_irq_o(irq), .err_cnt_o(cnt)
  );

  wb_slave_arbiter #(.NSLV(3)) dut3 (
    .wb_clk_i(clk), .wb_rst_n_i(rst_n),
    .wbs_cyc_i(cyc3), .wbs_stb_i(stb), .wbs_we_i(we),
    .wbs_sel_i(sel), .wbs_adr_i(adr), .wbs_dat_i(wdat),
    .wbs_ack_o(ack3), .wbs_dat_o(rdat3),
    .s_cyc_o(s_cyc3), .s_stb_o(s_stb3), .s_we_o(s_we3), .s_sel_o(s_sel3),
    .s_adr_o(s_adr3), .s_dat_o(s_wdat3),
    .s_ack_i(3'b000), .s_dat_i(96'h0),
    .err_clr_i(err_clr), .err_irq_o(irq3), .err_cnt_o(cnt3)
  );

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  task automatic req(input logic w, input logic [31:0] a, input logic [31:0] d, input logic [3:0] s);
    cyc = 1'b1; stb = 1'b1; we = w; adr = a; wdat = d; sel = s;
  endtask

  task automatic drop;
    cyc = 1'b0; stb = 1'b0; we = 1'b0;
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    step; step;
    n_cmp++; if ({ack, s_cyc, s_stb, s_we, s_sel, irq, cnt} !== 22'h0) begin n_bad++; $display("FAIL reset_ctrl: got %h want 0", {ack, s_cyc, s_stb, s_we, s_sel, irq, cnt}); end
    n_cmp++; if ({rdat, s_adr, s_wdat} !== 96'h0) begin n_bad++; $display("FAIL reset_data: got %h want 0", {rdat, s_adr, s_wdat}); end
    rst_n = 1'b1;
    step;
    $display("reset: released");
  endtask

  task automatic test_decode_miss;
    req(1'b0, 32'h2000_0000, 32'h0, 4'hF);
    step;
    n_cmp++; if ({s_stb, ack} !== 5'b0) begin n_bad++; $display("FAIL miss_no_stb: got stb=%b ack=%b want 0", s_stb, ack); end
    step;
    n_cmp++; if (ack !== 1'b1) begin n_bad++; $display("FAIL miss_ack: got %b want 1", ack); end
    n_cmp++; if (rdat !== 32'hDEAD_BEEF) begin n_bad++; $display("FAIL miss_dat: got %h want deadbeef", rdat); end
    n_cmp++; if ({irq, cnt} !== {1'b1, 8'd1}) begin n_bad++; $display("FAIL miss_err: got irq=%b cnt=%0d want 1/1", irq, cnt); end
    drop; step;
    $display("miss: adr=20000000 ack=%b dat=%h cnt=%0d", ack, rdat, cnt);
    use3 = 1'b1;
    req(1'b0, 32'h3003_0000, 32'h0, 4'hF);
    step;
    n_cmp++; if ({s_stb3, ack3} !== 4'b0) begin n_bad++; $display("FAIL miss3_no_stb: got stb=%b ack=%b want 0", s_stb3, ack3); end
    step;
    n_cmp++; if ({ack3, rdat3} !== {1'b1, 32'hDEAD_BEEF}) begin n_bad++; $display("FAIL miss3_ack: got ack=%b dat=%h want 1/deadbeef", ack3, rdat3); end
    n_cmp++; if ({irq3, cnt3} !== {1'b1, 8'd1}) begin n_bad++; $display("FAIL miss3_err: got irq=%b cnt=%0d want 1/1", irq3, cnt3); end
    drop; use3 = 1'b0; step;
    $display("miss: nslv3 idx3 ack=%b dat=%h cnt=%0d", ack3, rdat3, cnt3);
  endtask

  task automatic test_hit_read;
    s_dat[63:32] = 32'h1234_5678;
    req(1'b0, 32'h3001_0004, 32'h0, 4'hF);
    step;
    n_cmp++; if ({s_stb, s_cyc} !== 8'b0010_0010) begin n_bad++; $display("FAIL rd_stb: got stb=%b cyc=%b want 0010", s_stb, s_cyc); end
    n_cmp++; if ({s_adr, s_we} !== {32'h3001_0004, 1'b0}) begin n_bad++; $display("FAIL rd_adr: got %h we=%b want 30010004/0", s_adr, s_we); end
    s_ack[1] = 1'b1;
    step;
    s_ack[1] = 1'b0;
    n_cmp++; if ({s_stb, ack} !== 5'b0) begin n_bad++; $display("FAIL rd_stb_drop: got stb=%b ack=%b want 0", s_stb, ack); end
    step;
    n_cmp++; if ({ack, rdat} !== {1'b1, 32'h1234_5678}) begin n_bad++; $display("FAIL rd_ack: got ack=%b dat=%h want 1/12345678", ack, rdat); end
    drop; step;
    n_cmp++; if (ack !== 1'b0) begin n_bad++; $display("FAIL rd_ack_once: got %b want 0", ack); end
    $display("hit_read: adr=30010004 dat=%h", rdat);
  endtask

  task automatic test_write_wait;
    s_dat[127:96] = 32'h0BAD_0003;
    s_dat[31:0]   = 32'h1111_1111;
    req(1'b1, 32'h3003_0000, 32'hA5A5_A5A5, 4'b0011);
    for (int i = 0; i < 4; i++) begin
      step;
      s_ack = 4'b0000;
      if (i == 0) s_ack = 4'b0101;
      if (i == 3) s_ack = 4'b1000;
      n_cmp++; if ({s_stb, ack} !== 5'b1000_0) begin n_bad++; $display("FAIL wr_stb_c%0d: got stb=%b ack=%b want 1000/0", i, s_stb, ack); end
      n_cmp++; if ({s_we, s_sel, s_dat_o_chk()} !== {1'b1, 4'b0011, 32'hA5A5_A5A5}) begin n_bad++; $display("FAIL wr_req_c%0d: got we=%b sel=%b dat=%h", i, s_we, s_sel, s_wdat); end
    end
    step;
    s_ack = 4'b0000;
    n_cmp++; if ({s_stb, ack} !== 5'b0) begin n_bad++; $display("FAIL wr_stb_drop: got stb=%b ack=%b want 0", s_stb, ack); end
    step;
    n_cmp++; if ({ack, rdat} !== {1'b1, 32'h0BAD_0003}) begin n_bad++; $display("FAIL wr_ack: got ack=%b dat=%h want 1/0bad0003", ack, rdat); end
    n_cmp++; if (cnt !== 8'd1) begin n_bad++; $display("FAIL wr_no_err: got cnt=%0d want 1", cnt); end
    drop; step;
    $display("write_wait: adr=30030000 ack after 5 cycles dat=%h", rdat);
  endtask

  function automatic logic [31:0] s_dat_o_chk();
    return s_wdat;
  endfunction

  task automatic test_timeout;
    req(1'b0, 32'h3000_0010, 32'h0, 4'hF);
    for (int i = 0; i < 4; i++) begin
      step;
      n_cmp++; if ({s_stb, ack} !== 5'b0001_0) begin n_bad++; $display("FAIL tmo_stb_c%0d: got stb=%b ack=%b want 0001/0", i, s_stb, ack); end
    end
    step;
    n_cmp++; if ({s_stb, ack} !== 5'b0) begin n_bad++; $display("FAIL tmo_stb_drop: got stb=%b ack=%b want 0", s_stb, ack); end
    step;
    n_cmp++; if ({ack, rdat} !== {1'b1, 32'hDEAD_BEEF}) begin n_bad++; $display("FAIL tmo_ack: got ack=%b dat=%h want 1/deadbeef", ack, rdat); end
    n_cmp++; if ({irq, cnt} !== {1'b1, 8'd2}) begin n_bad++; $display("FAIL tmo_err: got irq=%b cnt=%0d want 1/2", irq, cnt); end
    drop; step;
    $display("timeout: slave0 dat=%h cnt=%0d", rdat, cnt);
  endtask

  task automatic test_abort_reset;
    req(1'b0, 32'h3002_0000, 32'h0, 4'hF);
    step;
    n_cmp++; if (s_stb !== 4'b0100) begin n_bad++; $display("FAIL abort_stb: got %b want 0100", s_stb); end
    drop;
    step;
    n_cmp++; if ({s_stb, ack} !== 5'b0) begin n_bad++; $display("FAIL abort_drop: got stb=%b ack=%b want 0", s_stb, ack); end
    for (int i = 0; i < 3; i++) begin
      step;
      n_cmp++; if (ack !== 1'b0) begin n_bad++; $display("FAIL abort_no_ack_c%0d: got %b want 0", i, ack); end
    end
    $display("abort: strobes dropped, no ack");
    req(1'b0, 32'h3000_0000, 32'h0, 4'hF);
    step;
    n_cmp++; if (s_stb !== 4'b0001) begin n_bad++; $display("FAIL rst_pre_stb: got %b want 0001", s_stb); end
    rst_n = 1'b0;
    #1;
    n_cmp++; if ({ack, s_cyc, s_stb, s_we, s_sel, irq, cnt} !== 22'h0) begin n_bad++; $display("FAIL async_rst_ctrl: got %h want 0", {ack, s_cyc, s_stb, s_we, s_sel, irq, cnt}); end
    n_cmp++; if ({rdat, s_adr} !== 64'h0) begin n_bad++; $display("FAIL async_rst_data: got %h want 0", {rdat, s_adr}); end
    drop;
    step;
    rst_n = 1'b1;
    step;
    s_dat[31:0] = 32'hCAFE_F00D;
    req(1'b0, 32'h3000_0008, 32'h0, 4'hF);
    step;
    n_cmp++; if (s_stb !== 4'b0001) begin n_bad++; $display("FAIL post_rst_stb: got %b want 0001", s_stb); end
    s_ack[0] = 1'b1;
    step;
    s_ack[0] = 1'b0;
    step;
    n_cmp++; if ({ack, rdat, cnt} !== {1'b1, 32'hCAFE_F00D, 8'd0}) begin n_bad++; $display("FAIL post_rst_ack: got ack=%b dat=%h cnt=%0d want 1/cafef00d/0", ack, rdat, cnt); end
    drop; step;
    $display("reset_mid_fwd: recovered, dat=%h", rdat);
  endtask

  task automatic test_err_flag;
    err_clr = 1'b1;
    req(1'b0, 32'h3100_0000, 32'h0, 4'hF);
    step; step;
    n_cmp++; if ({ack, irq, cnt} !== {1'b1, 1'b1, 8'd1}) begin n_bad++; $display("FAIL set_beats_clr: got ack=%b irq=%b cnt=%0d want 1/1/1", ack, irq, cnt); end
    drop; err_clr = 1'b0; step;
    err_clr = 1'b1; step; err_clr = 1'b0;
    n_cmp++; if ({irq, cnt} !== {1'b0, 8'd1}) begin n_bad++; $display("FAIL clr_irq: got irq=%b cnt=%0d want 0/1", irq, cnt); end
    $display("err_flag: set wins over clear, clear keeps count=%0d", cnt);
  endtask

  task automatic test_err_saturate;
    int exp_cnt;
    exp_cnt = 1;
    for (int i = 0; i < 300; i++) begin
      req(1'b0, (i % 2 == 0) ? 32'h0000_0000 : 32'hFF01_0000, 32'h0, 4'hF);
      step; step;
      drop; step;
      exp_cnt = (exp_cnt < 255) ? exp_cnt + 1 : 255;
      if (i == 252 || i == 253 || i == 299) begin
        n_cmp++; if (cnt !== 8'(exp_cnt)) begin n_bad++; $display("FAIL sat_cnt_i%0d: got %0d want %0d", i, cnt, exp_cnt); end
        $display("saturate: miss %0d cnt=%0d", i, cnt);
      end
    end
  endtask

  initial begin
    test_reset;
    test_decode_miss;
    test_hit_read;
    test_write_wait;
    test_timeout;
    test_abort_reset;
    test_err_flag;
    test_err_saturate;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/wb_slave_arbiter.md
# wb_slave_arbiter

Wishbone transaction scheduler that sits between the user-area Wishbone slave port and up to four user peripherals inside `user_project_wb_wrapper`. It decodes each management-SoC access to one peripheral window and forwards it as a single registered transaction. It returns the peripheral's data and acknowledge. If the address misses or the peripheral stalls past a timeout, it terminates the access itself with an error word, so the management core can never hang on the bus.

## Interface
Parameters:
- `NSLV`, 4: number of downstream slaves, 1..4.
- `BASE_HI`, 8'h30: required value of `wbs_adr_i[31:24]`.
- `WIN_BITS`, 16: log2 of window size; slave index = `wbs_adr_i[WIN_BITS+1:WIN_BITS]`.
- `TIMEOUT`, 255: maximum FWD cycles before forced error, 1..255.
- `ERR_DATA`, 32'hDEAD_BEEF: read data returned on error.

Ports (clock and reset first):
- `wb_clk_i` in 1: the single clock.
- `wb_rst_n_i` in 1: asynchronous, active-low reset.
- `wbs_cyc_i`, `wbs_stb_i`, `wbs_we_i` in 1 each: master request.
- `wbs_sel_i` in 4, `wbs_adr_i` in 32, `wbs_dat_i` in 32: master byte enables, address, write data.
- `wbs_ack_o` out 1, `wbs_dat_o` out 32: master acknowledge and read data.
- `s_cyc_o`, `s_stb_o` out NSLV: per-slave one-hot cycle and strobe.
- `s_we_o` out 1, `s_sel_o` out 4, `s_adr_o` out 32, `s_dat_o` out 32: shared registered request.
- `s_ack_i` in NSLV, `s_dat_i` in 32*NSLV: slave acknowledges and read data; slave k occupies `s_dat_i[32k+31:32k]`.
- `err_clr_i` in 1: clears the sticky error flag.
- `err_irq_o` out 1: sticky error flag; drives a `user_irq` bit.
- `err_cnt_o` out 8: saturating error count.

## Operation
FSM states: IDLE, FWD, ERR, ACK.

- **IDLE**
  - Waits for `wbs_cyc_i & wbs_stb_i`.
  - Hit: `adr[31:24]==BASE_HI` and index < NSLV. Latch index, adr, dat, sel and we, then go to FWD.
  - Any other request is a miss and goes to ERR.
- **FWD**
  - Drives `s_cyc_o[idx]=s_stb_o[idx]=1` from the latched registers and increments the wait counter.
  - `s_ack_i[idx]`: capture `s_dat_i[idx]`, drop `s_cyc_o`/`s_stb_o` next cycle, go to ACK.
  - Counter reaches TIMEOUT without ack: go to ERR.
  - `wbs_cyc_i` low (master abort): drop slave strobes and return to IDLE with no `wbs_ack_o`.
  - Acks on non-selected slaves are ignored.
- **ERR**
  - Capture ERR_DATA into the read register.
  - Set `err_irq_o` and increment `err_cnt_o`, saturating at 255.
  - Go to ACK.
- **ACK**
  - Assert `wbs_ack_o` for exactly one cycle with `wbs_dat_o` = captured word.
  - Go to IDLE; the wait counter clears.
- **Write data path:** writes return the captured slave data, or ERR_DATA on error. The master ignores it.
- **Error clear:** `err_clr_i` clears `err_irq_o` but not `err_cnt_o`. If an error sets on the same cycle as `err_clr_i`, the set wins.

## Timing
- Reset values: all outputs 0, `wbs_dat_o`=0, FSM=IDLE, counter=0. An asynchronous assertion mid-transaction drops all strobes immediately, and no ack is issued.
- Hit latency, with slave ack in the first FWD cycle:
  - Request sampled at edge 0.
  - `s_stb_o` high after edge 0.
  - `s_ack_i` seen at edge 1.
  - `wbs_ack_o` high after edge 2.
  - Each slave wait state adds one cycle.
- Miss latency: `wbs_ack_o` high after edge 1.
- Timeout: ack follows TIMEOUT FWD cycles + 2 cycles.
- `wbs_ack_o` is never high two consecutive cycles. The minimum transaction pitch is 3 cycles.
- A request still asserted in the cycle after ack is treated as a new transaction.
- All slave-side outputs are registered. No combinational path exists from `wbs_*` inputs to `s_*` outputs, or from `s_ack_i` to `wbs_ack_o`.

## Structure
- Package `wb_arb_pkg`:
  - state enum (IDLE/FWD/ERR/ACK);
  - default ERR_DATA;
  - `WB_DW`=32, `WB_AW`=32.
- Sub-module `wb_arb_timeout`: an 8-bit counter with clear/enable/expire. It is reused by later Wishbone blocks.
- The FSM, decode and muxing live in the top module.

## Test plan
- **Hit read:** read 0x3001_0004, slave1 acks on the first FWD cycle with 0x1234_5678. Required: `s_stb_o`=4'b0010 for exactly 1 cycle, `s_adr_o`=0x3001_0004; `wbs_ack_o` 2 cycles after the request with `wbs_dat_o`=0x1234_5678.
- **Hit write with wait states:** write 0x3003_0000, data 0xA5A5_A5A5, sel 4'b0011, slave3 acks after 3 waits. Required: `s_we_o`=1, `s_dat_o`/`s_sel_o` stable throughout; ack 5 cycles after the request.
- **Decode miss:** read 0x2000_0000, and separately index 3 with NSLV=3. Required: no `s_stb_o`; ack after 1 cycle, `wbs_dat_o`=0xDEAD_BEEF, `err_irq_o`=1, `err_cnt_o`=1.
- **Timeout:** TIMEOUT=4, slave0 never acks. Required: `s_stb_o[0]` high 4 cycles then low; error ack with 0xDEAD_BEEF; `err_cnt_o` increments.
- **Abort and reset:** drop `wbs_cyc_i` during FWD, then assert `wb_rst_n_i`=0 mid-FWD on the next access. Required: strobes drop with no ack; after reset, all outputs are 0 and a following hit completes normally.
- **Error flag and counter boundaries:** `err_clr_i` on the same cycle as a new error leaves `err_irq_o`=1. 300 misses saturate `err_cnt_o` at 255.
